// File: rtl/buzz_seq_if.sv
// Request/response bundle between the lock control FSM (master) and the
// beep-pattern sequencer (slave).
interface buzz_seq_if;
    logic       key_req;
    logic       ok_req;
    logic       err_req;
    logic       alarm_on;
    logic       buzz_en;
    logic       busy;
    logic [1:0] pat;

    modport master (
        output key_req, ok_req, err_req, alarm_on,
        input  buzz_en, busy, pat
    );

    modport slave (
        input  key_req, ok_req, err_req, alarm_on,
        output buzz_en, busy, pat
    );
endinterface

// File: rtl/buzz_seq.sv
// Beep-pattern sequencer: turns one-cycle event requests and a level alarm
// into timed buzz_en envelopes for the tone generator. Every pattern starts
// with a one-tick silent LEAD so the tone generator restarts in phase.
module buzz_seq #(
    parameter int unsigned TICK_CYC = 500000,
    parameter int unsigned KEY_ON   = 60,
    parameter int unsigned OK_ON    = 80,
    parameter int unsigned OK_GAP   = 40,
    parameter int unsigned ERR_ON   = 200
) (
    input  logic      clk,
    input  logic      rst_n,
    buzz_seq_if.slave bus
);
    localparam int unsigned   TW        = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);

    // Pattern codes double as priority: higher value wins.
    localparam logic [1:0] PAT_KEY = 2'd0;
    localparam logic [1:0] PAT_OK  = 2'd1;
    localparam logic [1:0] PAT_ERR = 2'd2;
    localparam logic [1:0] PAT_ALM = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_ON1,
        S_GAP,
        S_ON2,
        S_ALARM
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    dur_q, dur_d;
    logic [1:0]    pat_q, pat_d;
    logic          buzz_q, buzz_d;

    // Request bit order: {alarm, err, ok, key}. req_q is the registered
    // input, req_qq its one-cycle-old copy for edge detection.
    logic [3:0]    req_q, req_qq;
    logic [3:0]    rise;
    logic          trig;
    logic [1:0]    trig_pat;
    logic          tick;
    logic          done;
    logic          enter;
    logic [7:0]    on1_lim;
    logic [7:0]    lim;

    // Rising-edge triggers and their priority code.
    always_comb begin
        rise = req_q & ~req_qq;
        trig = |rise;
        if (rise[3])      trig_pat = PAT_ALM;
        else if (rise[2]) trig_pat = PAT_ERR;
        else if (rise[1]) trig_pat = PAT_OK;
        else              trig_pat = PAT_KEY;
    end

    // Tick pulse and per-state duration limit; done marks the exit tick.
    always_comb begin
        tick = (state_q != S_IDLE) && (tcnt_q == TICK_LAST);
        case (pat_q)
            PAT_KEY: on1_lim = 8'(KEY_ON);
            PAT_OK:  on1_lim = 8'(OK_ON);
            PAT_ERR: on1_lim = 8'(ERR_ON);
            default: on1_lim = 8'd1;
        endcase
        case (state_q)
            S_LEAD:  lim = 8'd1;
            S_ON1:   lim = on1_lim;
            S_GAP:   lim = 8'(OK_GAP);
            S_ON2:   lim = 8'(OK_ON);
            default: lim = 8'd0;
        endcase
        done = tick && ((dur_q + 8'd1) == lim);
    end

    // Next state, latched pattern, counters and registered buzz enable.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        enter   = 1'b0;
        if (trig && ((state_q == S_IDLE) || (trig_pat > pat_q))) begin
            // New pattern or strictly-higher-priority preemption; lower or
            // equal requests while busy are simply dropped.
            state_d = S_LEAD;
            pat_d   = trig_pat;
            enter   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_LEAD: begin
                    if ((pat_q == PAT_ALM) && !req_q[3])
                        state_d = S_IDLE;
                    else if (done)
                        state_d = (pat_q == PAT_ALM) ? S_ALARM : S_ON1;
                end
                S_ON1:   if (done) state_d = (pat_q == PAT_OK) ? S_GAP : S_IDLE;
                S_GAP:   if (done) state_d = S_ON2;
                S_ON2:   if (done) state_d = S_IDLE;
                S_ALARM: if (!req_q[3]) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            if (state_d != state_q) enter = 1'b1;
            if (state_d == S_IDLE)  pat_d = PAT_KEY;
        end

        buzz_d = (state_d == S_ON1) || (state_d == S_ON2) || (state_d == S_ALARM);

        // Counters restart on every state entry (including a re-entry of
        // LEAD on preemption) and hold at zero while idle.
        if (enter || (state_q == S_IDLE)) begin
            tcnt_d = '0;
            dur_d  = 8'd0;
        end else begin
            tcnt_d = tick ? '0 : tcnt_q + TW'(1);
            dur_d  = tick ? dur_q + 8'd1 : dur_q;
        end
    end

    // State and datapath registers; async reset clears buzz_en at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            dur_q   <= 8'd0;
            pat_q   <= PAT_KEY;
            buzz_q  <= 1'b0;
            req_q   <= 4'd0;
            req_qq  <= 4'd0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            dur_q   <= dur_d;
            pat_q   <= pat_d;
            buzz_q  <= buzz_d;
            req_q   <= {bus.alarm_on, bus.err_req, bus.ok_req, bus.key_req};
            req_qq  <= req_q;
        end
    end

    assign bus.buzz_en = buzz_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.pat     = pat_q;

endmodule

// File: tb/tb_buzz_seq.sv
// Directed bench for buzz_seq with TICK_CYC=4, KEY_ON=3, OK_ON=2, OK_GAP=1,
// ERR_ON=5. Sample k is taken at the k-th falling edge of a run, after which
// the inputs for the next rising edge are driven; an input driven at sample
// k yields LEAD at sample k+2.
module tb_buzz_seq;
    localparam int TL = 100;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [TL-1:0] bz_tr;
    logic [TL-1:0] by_tr;
    logic [1:0]    pat_tr [TL];

    buzz_seq_if bus();

    buzz_seq #(
        .TICK_CYC(4),
        .KEY_ON  (3),
        .OK_ON   (2),
        .OK_GAP  (1),
        .ERR_ON  (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Envelope with zeros, ones, zeros, ones, then zeros to the end.
    function automatic logic [TL-1:0] runs(input int z0, input int o0, input int z1, input int o1);
        logic [TL-1:0] v;
        v = '0;
        for (int i = 0; i < o0; i++) v[z0 + i] = 1'b1;
        for (int i = 0; i < o1; i++) v[z0 + o0 + z1 + i] = 1'b1;
        return v;
    endfunction

    // Records n samples while driving each request high for [start, start+len).
    task automatic run(input int n,
                       input int ks, input int kl, input int os, input int ol,
                       input int es, input int el, input int as0, input int al);
        bz_tr = '0;
        by_tr = '0;
        for (int i = 0; i < TL; i++) pat_tr[i] = 2'd0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bz_tr[k]  = bus.buzz_en;
            by_tr[k]  = bus.busy;
            pat_tr[k] = bus.pat;
            bus.key_req  = (k >= ks)  && (k < ks + kl);
            bus.ok_req   = (k >= os)  && (k < os + ol);
            bus.err_req  = (k >= es)  && (k < es + el);
            bus.alarm_on = (k >= as0) && (k < as0 + al);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_req = 1'b0; bus.ok_req = 1'b0; bus.err_req = 1'b0; bus.alarm_on = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.buzz_en !== 1'b0) begin errors++; $display("FAIL reset_buzz: got %b want 0", bus.buzz_en); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.pat !== 2'd0) begin errors++; $display("FAIL reset_pat: got %0d want 0", bus.pat); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_key();
        logic [TL-1:0] eb, ey;
        run(30, 0, 1, 0, 0, 0, 0, 0, 0);
        eb = runs(6, 12, 0, 0);
        ey = runs(2, 16, 0, 0);
        checks++;
        if (bz_tr !== eb) begin errors++; $display("FAIL key_buzz: got %h want %h", bz_tr, eb); end
        checks++;
        if (by_tr !== ey) begin errors++; $display("FAIL key_busy: got %h want %h", by_tr, ey); end
        checks++;
        if (pat_tr[10] !== 2'd0) begin errors++; $display("FAIL key_pat: got %0d want 0", pat_tr[10]); end
    endtask

    task automatic test_ok();
        logic [TL-1:0] eb, ey;
        run(35, 0, 0, 0, 1, 0, 0, 0, 0);
        eb = runs(6, 8, 4, 8);
        ey = runs(2, 24, 0, 0);
        checks++;
        if (bz_tr !== eb) begin errors++; $display("FAIL ok_buzz: got %h want %h", bz_tr, eb); end
        checks++;
        if (by_tr !== ey) begin errors++; $display("FAIL ok_busy: got %h want %h", by_tr, ey); end
        checks++;
        if (pat_tr[2] !== 2'd1 || pat_tr[15] !== 2'd1 || pat_tr[25] !== 2'd1)
        begin
            errors++;
            $display("FAIL ok_pat: got %0d/%0d/%0d want 1/1/1", pat_tr[2], pat_tr[15], pat_tr[25]);
        end
    endtask

    task automatic test_key_held();
        logic [TL-1:0] eb;
        run(60, 0, 40, 0, 0, 0, 0, 0, 0);
        eb = runs(6, 12, 0, 0);
        checks++;
        if (bz_tr !== eb) begin errors++; $display("FAIL held_buzz: got %h want %h", bz_tr, eb); end
    endtask

    task automatic test_err_preempt();
        logic [TL-1:0] eb, ey;
        run(45, 0, 1, 0, 0, 10, 1, 0, 0);
        eb = runs(6, 6, 4, 20);
        ey = runs(2, 34, 0, 0);
        checks++;
        if (bz_tr !== eb) begin errors++; $display("FAIL preempt_buzz: got %h want %h", bz_tr, eb); end
        checks++;
        if (by_tr !== ey) begin errors++; $display("FAIL preempt_busy: got %h want %h", by_tr, ey); end
        checks++;
        if (pat_tr[8] !== 2'd0 || pat_tr[12] !== 2'd2 || pat_tr[35] !== 2'd2) begin
            errors++;
            $display("FAIL preempt_pat: got %0d/%0d/%0d want 0/2/2", pat_tr[8], pat_tr[12], pat_tr[35]);
        end
    endtask

    task automatic test_drop_lower();
        logic [TL-1:0] eb;
        run(35, 10, 1, 0, 0, 0, 1, 0, 0);
        eb = runs(6, 20, 0, 0);
        checks++;
        if (bz_tr !== eb) begin errors++; $display("FAIL drop_buzz: got %h want %h", bz_tr, eb); end
        checks++;
        if (pat_tr[14] !== 2'd2) begin errors++; $display("FAIL drop_pat: got %0d want 2", pat_tr[14]); end
    endtask

    task automatic test_simultaneous();
        logic [TL-1:0] eb;
        run(35, 0, 1, 0, 0, 0, 1, 0, 0);
        eb = runs(6, 20, 0, 0);
        checks++;
        if (bz_tr !== eb) begin errors++; $display("FAIL simul_buzz: got %h want %h", bz_tr, eb); end
        checks++;
        if (pat_tr[3] !== 2'd2) begin errors++; $display("FAIL simul_pat: got %0d want 2", pat_tr[3]); end
    endtask

    task automatic test_alarm();
        logic [TL-1:0] eb, ey;
        run(75, 0, 0, 0, 1, 0, 0, 13, 50);
        eb = runs(6, 8, 5, 46);
        ey = runs(2, 63, 0, 0);
        checks++;
        if (bz_tr !== eb) begin errors++; $display("FAIL alarm_buzz: got %h want %h", bz_tr, eb); end
        checks++;
        if (by_tr !== ey) begin errors++; $display("FAIL alarm_busy: got %h want %h", by_tr, ey); end
        checks++;
        if (pat_tr[14] !== 2'd1 || pat_tr[15] !== 2'd3 || pat_tr[40] !== 2'd3) begin
            errors++;
            $display("FAIL alarm_pat: got %0d/%0d/%0d want 1/3/3", pat_tr[14], pat_tr[15], pat_tr[40]);
        end
    endtask

    task automatic test_alarm_lead_abort();
        logic [TL-1:0] eb, ey;
        run(15, 0, 0, 0, 0, 0, 0, 0, 2);
        eb = '0;
        ey = runs(2, 2, 0, 0);
        checks++;
        if (bz_tr !== eb) begin errors++; $display("FAIL abort_buzz: got %h want %h", bz_tr, eb); end
        checks++;
        if (by_tr !== ey) begin errors++; $display("FAIL abort_busy: got %h want %h", by_tr, ey); end
    endtask

    task automatic test_reset_mid_alarm();
        run(15, 0, 0, 0, 0, 0, 0, 0, 30);
        checks++;
        if (bz_tr[14] !== 1'b1) begin errors++; $display("FAIL pre_rst_buzz: got %b want 1", bz_tr[14]); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.buzz_en !== 1'b0 || bus.busy !== 1'b0 || bus.pat !== 2'd0) begin
            errors++;
            $display("FAIL async_rst: got buzz=%b busy=%b pat=%0d want 0/0/0", bus.buzz_en, bus.busy, bus.pat);
        end
        bus.alarm_on = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.buzz_en !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL no_resume: got buzz=%b busy=%b want 0/0", bus.buzz_en, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_key();
        test_ok();
        test_key_held();
        test_err_preempt();
        test_drop_lower();
        test_simultaneous();
        test_alarm();
        test_alarm_lead_abort();
        test_reset_mid_alarm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/buzz_seq.md
# buzz_seq

Beep-pattern sequencer for the digital lock's audible feedback. It converts one-cycle event requests (key press, unlock success, wrong code) and a level alarm into timed `buzz_en` on/off envelopes. These envelopes drive the existing tone generator, which produces the PWM tone and its 1 s gate from `buzz_en`. It sits between the lock control FSM and the tone generator, and is the only block allowed to drive `buzz_en`.

## Interface
- `TICK_CYC`, 500000: clk cycles per tick (10 ms at 50 MHz); range 2..2^20.
- `KEY_ON`, 60: key-beep on time, in ticks (1..255).
- `OK_ON`, 80: length of each of the two success beeps, in ticks (1..255).
- `OK_GAP`, 40: gap between the success beeps, in ticks (1..255).
- `ERR_ON`, 200: wrong-code beep on time, in ticks (1..255).
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `key_req`, in, 1: key-beep request; rising edge triggers.
- `ok_req`, in, 1: success-pattern request; rising edge triggers.
- `err_req`, in, 1: wrong-code request; rising edge triggers.
- `alarm_on`, in, 1: continuous alarm while high (level).
- `buzz_en`, out, 1: enable to the tone generator, registered.
- `busy`, out, 1: high whenever the state is not IDLE.
- `pat`, out, 2: active pattern: 0 none/key, 1 ok, 2 err, 3 alarm.

## Operation
- Request inputs are registered once. A trigger is `req & ~req_q`, so a held level fires only once.
- Priority: alarm > err > ok > key. The priority code is computed from triggers in the current cycle plus `alarm_on`.
- States: IDLE, LEAD, ON1, GAP, ON2, ALARM.
  - IDLE: `buzz_en`=0.
  - LEAD: `buzz_en`=0 for exactly 1 tick. This guarantees the tone generator's counters are reset so every beep starts in phase.
  - ON1: `buzz_en`=1 for KEY_ON, OK_ON, or ERR_ON ticks, selected by `pat`.
  - GAP: ok pattern only, `buzz_en`=0 for OK_GAP ticks.
  - ON2: ok pattern only, `buzz_en`=1 for OK_ON ticks.
  - ALARM: `buzz_en`=1 while `alarm_on`=1.
- Transitions:
  - Any trigger in IDLE goes to LEAD with `pat` latched.
  - LEAD goes to ON1.
  - ON1 goes to IDLE (key, err) or to GAP (ok). GAP goes to ON2. ON2 goes to IDLE.
  - A rising `alarm_on` from any state goes to LEAD with `pat`=3. LEAD then goes to ALARM.
  - ALARM goes to IDLE one cycle after `alarm_on` falls.
- Preemption: a trigger of strictly higher priority than the active `pat` aborts the pattern and enters LEAD. The tick counter and duration counter restart. Equal- or lower-priority triggers while busy are dropped and not queued.
- If `alarm_on` falls during LEAD with `pat`=3, go to IDLE.
- Tick counter: `ceil(log2(TICK_CYC))` bits, counts 0..TICK_CYC-1. It runs only when not IDLE and is cleared on every state entry. A tick pulse fires at count TICK_CYC-1.
- Duration counter: 8 bits, cleared on state entry, incremented on each tick. The state exits on the tick where count+1 equals the programmed value.

## Timing
- Reset values: state=IDLE, `buzz_en`=0, `busy`=0, `pat`=0, counters=0, `req_q`=0.
- Request latency:
  - Trigger seen at edge N gives state=LEAD and `busy`=1 after edge N+1.
  - `buzz_en` rises TICK_CYC cycles after LEAD entry.
- On-time: `buzz_en` high for exactly D×TICK_CYC cycles, where D is the duration parameter. It falls on the same edge as the state exit.
- Total ok pattern length: (1+2×OK_ON+OK_GAP)×TICK_CYC cycles from LEAD entry to IDLE.
- Reset mid-pattern forces `buzz_en`=0 immediately (asynchronous). The pattern is not resumed after reset.
- Simultaneous `key_req` and `err_req` triggers in the same cycle: err wins and key is dropped.

## Test plan
Bench parameters: TICK_CYC=4, KEY_ON=3, OK_ON=2, OK_GAP=1, ERR_ON=5.
- Single key pulse → `busy` rises 1 cycle later; `buzz_en` goes 0 for 4 cycles, then 1 for 12 cycles, then 0; `busy` falls with `buzz_en`.
- ok pulse → `buzz_en` sequence 4×0, 8×1, 4×0, 8×1, then 0; `pat`=1 throughout.
- `key_req` held high for 40 cycles → exactly one 12-cycle beep.
- err pulse 6 cycles into a key beep's ON1 → `buzz_en` drops, LEAD of 4 cycles, then 20 cycles high; `pat`=2.
- key pulse during err ON1 → ignored; err beep completes its full 20 cycles.
- `alarm_on` raised during ok GAP, held 50 cycles → LEAD of 4 cycles, then `buzz_en`=1 until 1 cycle after fall; `rst_n` pulse mid-alarm → `buzz_en`=0 asynchronously and all outputs at reset values.
